// File: rtl/uart.sv
// ----------------------------------------------------------------------------
// uart -- byte-wide memory-mapped 8N1 UART (transmitter, receiver, status).
//
// Serial console of the j1_top CPU and host-side terminal model in system
// simulation. The CPU/host writes bytes to transmit, polls the status byte and
// reads received bytes over a simple rd/wr/adr strobe bus.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (default 868 = 100 MHz / 115200).
//                 Must be at least 4.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   rx     in   1  serial input, idle high, asynchronous to clk
//   tx     out  1  serial output, idle high, registered
//   wr     in   1  write strobe (one cycle per access)
//   rd     in   1  read strobe (one cycle per access)
//   adr    in   2  adr[1]=0 data register, adr[1]=1 status; adr[0] ignored
//   din    in   8  write data
//   dout   out  8  read data, combinational from adr
//   dout1  out  8  status byte, always visible
//
// Status byte: bit0 rx_valid, bit1 tx_busy, bit2 rx_overrun, bits7:3 zero.
//
// Bus handshake: a write to adr[1]=0 is accepted only while tx_busy=0 (a
// write while busy is dropped); a read strobe to adr[1]=0 consumes the
// received byte by clearing rx_valid and rx_overrun. There is no back-pressure
// beyond the status bits: software polls tx_busy / rx_valid.
//
// Optional build macro
//   UART_LOOPBACK_EN  receiver is fed from the transmitter's internal serial
//                     output, the rx pin is ignored and the tx pin is held 1.
// ----------------------------------------------------------------------------
module uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] dout1
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- TX ----
  logic [1:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx;
  logic          r_tx_busy;
  logic          w_wr_data;

  assign w_wr_data = wr && !adr[1] && !r_tx_busy;

  // r_tx is updated on the same edge as each state change, so the line level
  // always matches the bit being sent and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          if (w_wr_data) begin
            r_tx_shift <= din;
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == C_BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == C_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == C_BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------- pin / loopback ----
  logic w_rx_in;
  logic w_unused;

`ifdef UART_LOOPBACK_EN
  assign w_rx_in  = r_tx;
  assign tx       = 1'b1;
  assign w_unused = adr[0] ^ rx;
`else
  assign w_rx_in  = rx;
  assign tx       = r_tx;
  assign w_unused = adr[0];
`endif

  // ---------------------------------------------------------------- RX ----
  // Synchronizer flops reset to the idle line level so reset release cannot
  // look like a start bit.
  logic r_rx_s1;
  logic r_rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= w_rx_in;
      r_rx_s2 <= r_rx_s1;
    end
  end

  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_done;

  // A good frame completes at the stop-bit centre with the line high.
  assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == C_BIT_LAST) && r_rx_s2;

  // After the half-bit start check every later sample lands on a bit centre.
  // Leaving STOP at its centre lets an immediately following start bit be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == C_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == C_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == C_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------ rx data / status ----
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_overrun;
  logic       w_rd_data;

  assign w_rd_data = rd && !adr[1];

  // A completing byte takes priority over a clearing read in the same cycle;
  // overrun is only flagged when the previous byte was left unread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else if (w_rx_done) begin
      r_rx_data  <= r_rx_shift;
      r_rx_valid <= 1'b1;
      if (w_rd_data)       r_rx_overrun <= 1'b0;
      else if (r_rx_valid) r_rx_overrun <= 1'b1;
    end else if (w_rd_data) begin
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end
  end

  logic [7:0] w_status;
  assign w_status = {5'b0, r_rx_overrun, r_tx_busy, r_rx_valid};
  assign dout1    = w_status;
  assign dout     = adr[1] ? w_status : r_rx_data;

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
module tb_uart;

  localparam int CPB = 16;

  // ------------------------------------------------ clock and reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ DUT ----
  logic       tb_rx, dut_rx, use_peer, tx, wr, rd;
  logic [1:0] adr;
  logic [7:0] din, dout, dout1;

  logic       p_tx, p_wr, p_rd;
  logic [1:0] p_adr;
  logic [7:0] p_din, p_dout, p_dout1;

  assign dut_rx = use_peer ? p_tx : tb_rx;

  uart #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst(rst), .rx(dut_rx), .tx(tx), .wr(wr), .rd(rd),
    .adr(adr), .din(din), .dout(dout), .dout1(dout1)
  );

  // Second UART used as a far-end terminal, cross-connected to the DUT.
  uart #(.CLKS_PER_BIT(CPB)) u_peer (
    .clk(clk), .rst(rst), .rx(tx), .tx(p_tx), .wr(p_wr), .rd(p_rd),
    .adr(p_adr), .din(p_din), .dout(p_dout), .dout1(p_dout1)
  );

  // ------------------------------------------------------ scoreboard ----
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // --------------------------------------------------- driver tasks ----
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; adr = a; din = d;
    @(negedge clk);
    wr = 1'b0; adr = 2'b00;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk);
    rd = 1'b1; adr = a;
    @(negedge clk);
    rd = 1'b0; adr = 2'b00;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    tb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    tb_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!dout1[1]) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  // ------------------------------------------------ TX line monitor ----
  // Decodes frames on tx by sampling at bit centres; a frame interrupted by
  // reset is discarded without consuming an expected byte.
  task automatic mon_wait(input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  initial begin : tx_monitor
    bit         ab, a;
    logic       st, sp;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_wait(CPB / 2 - 1, a); ab = a;
        st = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, a); ab |= a;
          b[i] = tx;
        end
        mon_wait(CPB, a); ab |= a;
        sp = tx;
        if (!ab) begin
          if (exp_tx_q.size() == 0) begin
            fail_now("tx_unexpected_frame");
          end else begin
            chk("tx_start_bit", {7'b0, st}, 8'h00);
            chk("tx_byte", b, exp_tx_q.pop_front());
            chk("tx_stop_bit", {7'b0, sp}, 8'h01);
          end
        end
        while (tx !== 1'b1) @(negedge clk);
      end
    end
  end

  // -------------------------------------------------- RX monitor ----
  // A received byte shows up as rx_valid or rx_overrun rising; adr idles at
  // the data register, so dout then carries the byte.
  initial begin : rx_monitor
    logic pv, po, v, o;
    pv = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk);
      v = dout1[0]; o = dout1[2];
      if ((v && !pv) || (o && !po)) begin
        if (exp_rx_q.size() == 0) fail_now("rx_unexpected_byte");
        else chk("rx_byte", dout, exp_rx_q.pop_front());
      end
      pv = v; po = o;
    end
  end

  // ---------------------------------------------------- stimulus ----
  string msg;

  initial begin : stimulus
    rst = 1'b1; tb_rx = 1'b1; use_peer = 1'b0;
    wr = 1'b0; rd = 1'b0; adr = 2'b00; din = 8'h00;
    p_wr = 1'b0; p_rd = 1'b0; p_adr = 2'b00; p_din = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", {7'b0, tx}, 8'h01);
    chk("reset_status", dout1, 8'h00);
    chk("reset_data", dout, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Transmit 0x55: busy on the next edge, clear 160 cycles after latching.
    exp_tx_q.push_back(8'h55);
    bus_write(2'b00, 8'h55);
    chk("tx_busy_set", dout1, 8'h02);
    repeat (10 * CPB - 1) @(negedge clk);
    chk("tx_busy_hold", dout1, 8'h02);
    @(negedge clk);
    chk("tx_busy_clear", dout1, 8'h00);

    // Write to the status address is ignored.
    bus_write(2'b10, 8'hAA);
    chk("wr_status_ignored", dout1, 8'h00);
    repeat (20) @(negedge clk);

    // Second write during the frame is dropped.
    exp_tx_q.push_back(8'h41);
    bus_write(2'b00, 8'h41);
    repeat (30) @(negedge clk);
    bus_write(2'b00, 8'h42);
    wait_tx_idle("tx_idle_timeout");
    repeat (200) @(negedge clk);

    // Receive 0x3A, check mux, then a data read clears status.
    exp_rx_q.push_back(8'h3A);
    drive_frame(8'h3A, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx_status", dout1, 8'h01);
    chk("rx_data", dout, 8'h3A);
    adr = 2'b10;
    #1 chk("rx_status_mux", dout, 8'h01);
    adr = 2'b00;
    bus_read(2'b00);
    chk("rx_read_clear", dout1, 8'h00);

    // Overrun: two frames back to back without a read.
    exp_rx_q.push_back(8'h31);
    drive_frame(8'h31, 1'b1);
    exp_rx_q.push_back(8'h32);
    drive_frame(8'h32, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovr_status", dout1, 8'h05);
    chk("ovr_data", dout, 8'h32);
    bus_read(2'b10);
    chk("status_read_no_clear", dout1, 8'h05);
    bus_read(2'b00);
    chk("ovr_clear", dout1, 8'h00);

    // 3-cycle glitch and a framing error both produce nothing.
    tb_rx = 1'b0;
    repeat (3) @(negedge clk);
    tb_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_byte", dout1, 8'h00);
    drive_frame(8'h5A, 1'b0);
    tb_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("framing_no_byte", dout1, 8'h00);

    // Asynchronous reset in the middle of a transmit with a byte pending.
    exp_rx_q.push_back(8'h77);
    drive_frame(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    bus_write(2'b00, 8'h00);
    repeat (20) @(negedge clk);
    chk("pre_rst_tx_low", {7'b0, tx}, 8'h00);
    chk("pre_rst_status", dout1, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", {7'b0, tx}, 8'h01);
    chk("rst_async_status", dout1, 8'h00);
    chk("rst_async_data", dout, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Far-end UART sends a console line; the DUT reads each byte as it lands.
    msg = ": w 30 0 do i . loop ;  w w";
    use_peer = 1'b1;
    repeat (5) @(negedge clk);
    fork
      begin : sender
        for (int i = 0; i <= msg.len(); i++) begin
          logic [7:0] c;
          bit         idle;
          c = (i == msg.len()) ? 8'h0D : 8'(msg[i]);
          idle = 1'b0;
          for (int k = 0; k < 400 && !idle; k++) begin
            @(negedge clk);
            if (!p_dout1[1]) idle = 1'b1;
          end
          if (!idle) fail_now("peer_tx_timeout");
          exp_rx_q.push_back(c);
          p_wr = 1'b1; p_din = c;
          @(negedge clk);
          p_wr = 1'b0;
        end
      end
      begin : reader
        for (int i = 0; i <= msg.len(); i++) begin
          bit got;
          got = 1'b0;
          for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (dout1[0]) got = 1'b1;
          end
          if (!got) fail_now("string_rx_timeout");
          rd = 1'b1;
          @(negedge clk);
          rd = 1'b0;
        end
      end
    join
    repeat (50) @(negedge clk);
    chk("string_no_overrun", dout1, 8'h00);

    chk("tx_queue_empty", 8'(exp_tx_q.size()), 8'h00);
    chk("rx_queue_empty", 8'(exp_rx_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
